// File: rtl/fp_accum_seq_if.sv
// fp_accum_seq_if: operand stream, adder hookup and block-sum stream of
// fp_accum_seq. The slave modport is the accumulator; the master modport is
// its parent (operand source, sum consumer and the fpAdder wiring).
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1. A source holds valid and data stable until
// that edge. The sink never waits for valid before raising ready.
interface fp_accum_seq_if #(
    parameter int LEN = 8
);
    localparam int CW = $clog2(LEN + 1);

    // control
    logic          i_clear;
    // operand stream
    logic          i_in_valid;
    logic          o_in_ready;
    logic [31:0]   i_in_data;
    logic          i_in_sub;
    // adder connections
    logic [31:0]   o_add_a;
    logic [31:0]   o_add_b;
    logic          o_add_op;
    logic [31:0]   i_add_result;
    // block-sum stream
    logic          o_out_valid;
    logic          i_out_ready;
    logic [31:0]   o_out_data;
    // status / debug
    logic [CW-1:0] o_count;
    logic [1:0]    o_dbg_state;

    modport slave (
        input  i_clear,
        input  i_in_valid,
        output o_in_ready,
        input  i_in_data,
        input  i_in_sub,
        output o_add_a,
        output o_add_b,
        output o_add_op,
        input  i_add_result,
        output o_out_valid,
        input  i_out_ready,
        output o_out_data,
        output o_count,
        output o_dbg_state
    );

    modport master (
        output i_clear,
        output i_in_valid,
        input  o_in_ready,
        output i_in_data,
        output i_in_sub,
        input  o_add_a,
        input  o_add_b,
        input  o_add_op,
        output i_add_result,
        input  o_out_valid,
        output i_out_ready,
        input  o_out_data,
        input  o_count,
        input  o_dbg_state
    );
endinterface

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequential feeder/collector around a combinational fpAdder
// that lives beside this block. Sums blocks of LEN single-precision operands
// (each added or subtracted) and presents every block sum on a valid/ready
// port. The first operand of a block bypasses the adder (sign-flipped when it
// is a subtraction) because the adder has no representation for zero.
//
// Build option: define FPACC_OPREG_EN to register the adder operands. Each
// non-first operand then takes an extra EXEC cycle (one operand per 2 cycles).
// Without it the adder inputs are combinational and throughput is 1/cycle.
module fp_accum_seq #(
    parameter int LEN = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    fp_accum_seq_if.slave bus
);
    localparam int            CW   = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

`ifdef FPACC_OPREG_EN
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        HOLD = 2'd2
    } state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [31:0]   acc;
    logic [CW-1:0] cnt;
    logic          in_ready;
    logic          hs_in;
    logic          is_first;
    logic          is_last;
    logic [31:0]   first_val;

    // Position of the operand being offered within its block.
    assign is_first  = (cnt == '0);
    assign is_last   = (cnt == LAST);
    // First operand enters the accumulator directly; subtraction flips its sign.
    assign first_val = {bus.i_in_data[31] ^ bus.i_in_sub, bus.i_in_data[30:0]};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and input-handshake qualification; clear wins over all.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        hs_in      = 1'b0;
        case (state)
            ACC: begin
                in_ready = ~bus.i_clear;
                hs_in    = bus.i_in_valid & in_ready;
                if (hs_in) begin
`ifdef FPACC_OPREG_EN
                    if (is_first) begin
                        state_next = is_last ? HOLD : ACC;
                    end else begin
                        state_next = EXEC;
                    end
`else
                    state_next = is_last ? HOLD : ACC;
`endif
                end
            end
`ifdef FPACC_OPREG_EN
            // cnt already wrapped to 0 when the operand in flight was the last one.
            EXEC: begin
                state_next = (cnt == '0) ? HOLD : ACC;
            end
`endif
            HOLD: begin
                if (bus.i_out_ready) begin
                    state_next = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
        if (bus.i_clear) begin
            state_next = ACC;
        end
    end

    // Accumulator and operand counter; clear drops the count but keeps acc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (bus.i_clear) begin
            cnt <= '0;
        end else if (hs_in) begin
            cnt <= is_last ? '0 : cnt + CW'(1);
            if (is_first) begin
                acc <= first_val;
            end
`ifndef FPACC_OPREG_EN
            else begin
                acc <= bus.i_add_result;
            end
`endif
        end
`ifdef FPACC_OPREG_EN
        else if (state == EXEC) begin
            acc <= bus.i_add_result;
        end
`endif
    end

`ifdef FPACC_OPREG_EN
    logic [31:0] add_a_q;
    logic [31:0] add_b_q;
    logic        add_op_q;

    // Latch the adder operands on every non-first handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_op_q <= 1'b0;
        end else if (hs_in && !is_first) begin
            add_a_q  <= acc;
            add_b_q  <= bus.i_in_data;
            add_op_q <= bus.i_in_sub;
        end
    end

    assign bus.o_add_a  = add_a_q;
    assign bus.o_add_b  = add_b_q;
    assign bus.o_add_op = add_op_q;
`else
    assign bus.o_add_a  = acc;
    assign bus.o_add_b  = bus.i_in_data;
    assign bus.o_add_op = bus.i_in_sub;
`endif

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = (state == HOLD);
    assign bus.o_out_data  = acc;
    assign bus.o_count     = cnt;
    assign bus.o_dbg_state = state;

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: randomized and directed bench for fp_accum_seq.
// Three instances (LEN=4, 2, 1). The adder beside each instance is modelled
// with real arithmetic; stimulus uses quarter-integer values so every sum is
// exact in single precision. Expected block sums come from a plain real-valued
// running sum of the signed operands.
module tb_fp_accum_seq;
`ifdef FPACC_OPREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic i_clk;
    logic i_rst_n;

    fp_accum_seq_if #(.LEN(4)) a4 ();
    fp_accum_seq_if #(.LEN(2)) a2 ();
    fp_accum_seq_if #(.LEN(1)) a1 ();

    fp_accum_seq #(.LEN(4)) dut4 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(a4));
    fp_accum_seq #(.LEN(2)) dut2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(a2));
    fp_accum_seq #(.LEN(1)) dut1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(a1));

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] add_vec [4];

    // ---------------- float helpers (finite values only) ----------------
    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(e));
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic s;
        int   e;
        int   frac;
        logic [7:0] ef;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        if (s) v = -v;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        frac = $rtoi((v - 1.0) * 8388608.0);
        ef   = 8'(e + 127);
        return {s, ef, frac[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
        return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_val();
        int k;
        k = $urandom_range(1, 128);
        return r2f(($urandom_range(0, 1) == 1) ? -real'(k) / 4.0 : real'(k) / 4.0);
    endfunction

    // Adder models beside the instances; the LEN=1 adder returns junk on purpose.
    always_comb a4.i_add_result = fp_add(a4.o_add_a, a4.o_add_b, a4.o_add_op);
    always_comb a2.i_add_result = fp_add(a2.o_add_a, a2.o_add_b, a2.o_add_op);
    assign a1.i_add_result = 32'hDEADBEEF;

    // ---------------- clock ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- LEN=4 drivers ----------------
    task automatic push4(input logic [31:0] d, input logic s);
        bit hs = 0;
        a4.i_in_valid = 1'b1;
        a4.i_in_data  = d;
        a4.i_in_sub   = s;
        for (int k = 0; k < 64 && !hs; k++) begin
            #1 hs = a4.o_in_ready;
            @(negedge i_clk);
        end
        a4.i_in_valid = 1'b0;
        check("in_accept", 32'(hs), 32'd1);
    endtask

    task automatic wait_out4();
        bit seen = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            if (a4.o_out_valid) seen = 1;
            else @(negedge i_clk);
        end
        check("out_valid_wait", 32'(seen), 32'd1);
    endtask

    task automatic pop4(input int delay);
        logic [31:0] e;
        wait_out4();
        repeat (delay) @(negedge i_clk);
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        check("block_sum", a4.o_out_data, e);
        a4.i_out_ready = 1'b1;
        @(negedge i_clk);
        a4.i_out_ready = 1'b0;
        check("out_drop", 32'(a4.o_out_valid), 32'd0);
    endtask

    // One random block of 4 operands; expected sum is a plain signed real sum.
    task automatic run_block(input int gap_max);
        real         sum;
        logic [31:0] d;
        logic        s;
        sum = 0.0;
        for (int i = 0; i < 4; i++) begin
            d = rnd_val();
            s = 1'($urandom_range(0, 1));
            sum = s ? sum - f2r(d) : sum + f2r(d);
            repeat ($urandom_range(0, gap_max)) @(negedge i_clk);
            push4(d, s);
            check("count", 32'(a4.o_count), 32'((i + 1) % 4));
        end
        exp_q.push_back(r2f(sum));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        add_vec = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000};
        i_rst_n = 1'b0;
        {a4.i_clear, a4.i_in_valid, a4.i_in_sub, a4.i_out_ready} = '0;
        {a2.i_clear, a2.i_in_valid, a2.i_in_sub, a2.i_out_ready} = '0;
        {a1.i_clear, a1.i_in_valid, a1.i_in_sub, a1.i_out_ready} = '0;
        a4.i_in_data = '0;
        a2.i_in_data = '0;
        a1.i_in_data = '0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(a4.o_out_valid), 32'd0);
        check("rst_out_data", a4.o_out_data, 32'd0);
        check("rst_count", 32'(a4.o_count), 32'd0);
        check("rst_in_ready", 32'(a4.o_in_ready), 32'd1);
        check("rst_add_a", a4.o_add_a, 32'd0);
        check("rst_add_b", a4.o_add_b, 32'd0);
        check("rst_add_op", 32'(a4.o_add_op), 32'd0);
        @(negedge i_clk);

        // Directed add block: 1 + 2 + 0.5 + 0.5 = 4.0.
        for (int i = 0; i < 4; i++) begin
            push4(add_vec[i], 1'b0);
            check("add_count", 32'(a4.o_count), 32'((i + 1) % 4));
        end
        repeat (LAT - 1) @(negedge i_clk);
        check("add_valid_latency", 32'(a4.o_out_valid), 32'd1);
        exp_q.push_back(32'h40800000);
        pop4(0);

        // Output backpressure: 5 cycles in HOLD with a pending operand.
        run_block(0);
        wait_out4();
        a4.i_in_data  = rnd_val();
        a4.i_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_data", a4.o_out_data, exp_q[0]);
            check("bp_in_ready", 32'(a4.o_in_ready), 32'd0);
            check("bp_valid", 32'(a4.o_out_valid), 32'd1);
            check("bp_count", 32'(a4.o_count), 32'd0);
            @(negedge i_clk);
        end
        a4.i_in_valid = 1'b0;
        pop4(0);
        check("after_bp_count", 32'(a4.o_count), 32'd0);

        // Clear mid-block after two operands, with an operand on offer.
        push4(rnd_val(), 1'b0);
        push4(rnd_val(), 1'b1);
        a4.i_in_data  = rnd_val();
        a4.i_in_valid = 1'b1;
        a4.i_clear    = 1'b1;
        #1 check("clr_in_ready", 32'(a4.o_in_ready), 32'd0);
        @(negedge i_clk);
        a4.i_clear    = 1'b0;
        a4.i_in_valid = 1'b0;
        check("clr_count", 32'(a4.o_count), 32'd0);
        check("clr_valid", 32'(a4.o_out_valid), 32'd0);
        run_block(1);
        pop4(1);

        // Clear in HOLD beats a simultaneous output handshake.
        run_block(0);
        wait_out4();
        a4.i_clear     = 1'b1;
        a4.i_out_ready = 1'b1;
        @(negedge i_clk);
        a4.i_clear     = 1'b0;
        a4.i_out_ready = 1'b0;
        check("clr_hold_valid", 32'(a4.o_out_valid), 32'd0);
        check("clr_hold_count", 32'(a4.o_count), 32'd0);
        void'(exp_q.pop_front());

        // Random blocks with idle gaps and consumer delays.
        for (int b = 0; b < 6; b++) begin
            run_block(2);
            pop4($urandom_range(0, 3));
        end

        // LEN=2: subtraction on the first operand.
        a2.i_in_data  = 32'h40000000;
        a2.i_in_sub   = 1'b1;
        a2.i_in_valid = 1'b1;
        #1 check("l2_ready0", 32'(a2.o_in_ready), 32'd1);
        @(negedge i_clk);
        a2.i_in_valid = 1'b0;
        check("l2_acc_first", a2.o_out_data, 32'hC0000000);
        check("l2_count", 32'(a2.o_count), 32'd1);
        a2.i_in_data  = 32'h3F800000;
        a2.i_in_sub   = 1'b0;
        a2.i_in_valid = 1'b1;
        #1 check("l2_ready1", 32'(a2.o_in_ready), 32'd1);
        @(negedge i_clk);
        a2.i_in_valid = 1'b0;
        for (int k = 0; k < 8 && !a2.o_out_valid; k++) @(negedge i_clk);
        check("l2_valid", 32'(a2.o_out_valid), 32'd1);
        check("l2_sum", a2.o_out_data, 32'hBF800000);
        a2.i_out_ready = 1'b1;
        @(negedge i_clk);
        a2.i_out_ready = 1'b0;
        check("l2_drop", 32'(a2.o_out_valid), 32'd0);

        // LEN=1: sign flip only, adder result ignored.
        a1.i_in_data  = 32'h40400000;
        a1.i_in_sub   = 1'b1;
        a1.i_in_valid = 1'b1;
        #1 check("l1_ready", 32'(a1.o_in_ready), 32'd1);
        @(negedge i_clk);
        a1.i_in_valid = 1'b0;
        check("l1_valid", 32'(a1.o_out_valid), 32'd1);
        check("l1_sum", a1.o_out_data, 32'hC0400000);
        check("l1_count", 32'(a1.o_count), 32'd0);
        a1.i_out_ready = 1'b1;
        @(negedge i_clk);
        a1.i_out_ready = 1'b0;

        // Asynchronous reset mid-cycle while holding a sum.
        run_block(0);
        wait_out4();
        a4.i_in_data = '0;
        a4.i_in_sub  = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(a4.o_out_valid), 32'd0);
        check("arst_data", a4.o_out_data, 32'd0);
        check("arst_count", 32'(a4.o_count), 32'd0);
        check("arst_add_a", a4.o_add_a, 32'd0);
        check("arst_add_op", 32'(a4.o_add_op), 32'd0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_block(1);
        pop4(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Sequential operand feeder and result collector wrapped around the combinational single-precision `fpAdder`. It accepts a valid/ready stream of IEEE-754 single-precision operands and drives the adder's `a`, `b` and `operation` inputs. It folds the adder result back into an accumulator register and presents the sum of each block of `LEN` operands on a valid/ready output port. The adder is instantiated beside this block at the parent level; all adder connections are ports.

## Interface
- `LEN`, default 8 — operands per accumulation block, ≥1.
- `i_clk  in  1` — clock; all state updates on the rising edge.
- `i_rst_n  in  1` — reset, asynchronous, active-low.
- `i_clear  in  1` — synchronous abort: drop the partial block and return to empty.
- `i_in_valid  in  1` — input operand valid.
- `o_in_ready  out  1` — block accepts an operand this cycle.
- `i_in_data  in  32` — operand (IEEE-754 single).
- `i_in_sub  in  1` — 1 means subtract this operand from the sum; 0 means add it.
- `o_add_a  out  32` — to adder `i_data_a`.
- `o_add_b  out  32` — to adder `i_data_b`.
- `o_add_op  out  1` — to adder `i_operation`.
- `i_add_result  in  32` — from adder `o_cal_result`.
- `o_out_valid  out  1` — block sum valid.
- `i_out_ready  in  1` — consumer accepts the sum.
- `o_out_data  out  32` — block sum.
- `o_count  out  $clog2(LEN+1)` — operands accepted in the current block.

## Operation
- State is held in `state`, `acc[31:0]` and `cnt`.
- FSM states: `ACC`, `EXEC` (exists only with the macro defined), and `HOLD`.
- A handshake occurs when `i_in_valid & o_in_ready`. `o_in_ready` is 1 only in `ACC` while `i_clear` = 0.
- **First operand of a block (`cnt`=0):** bypasses the adder.
  - Load `acc <= {i_in_data[31]^i_in_sub, i_in_data[30:0]}`.
  - The adder cannot represent zero, so it is never given an initial +0.0.
- **Later operands:** `acc <= i_add_result`, computed from `a`=acc, `b`=operand, `op`=`i_in_sub`.
- **Counter:** `cnt` increments on every handshake. When the handshake carries operand number `LEN`, `cnt` clears to 0 and the FSM goes to `HOLD` once `acc` holds the final value.
- **`HOLD`:**
  - `o_out_valid`=1 and `o_out_data`=acc; both stay stable until `i_out_ready`.
  - `o_in_ready`=0, so blocks never overlap.
  - On `i_out_ready` the FSM returns to `ACC`.
- **`LEN`=1:** each operand passes through the sign-flip rule alone and goes straight to `HOLD`.
- **`i_clear`:**
  - In any state it sets state to `ACC` and `cnt` to 0, and forces `o_out_valid` to 0 the next cycle.
  - It takes priority over a simultaneous input or output handshake. Since `o_in_ready` is 0 while `i_clear` is 1, no input handshake occurs.
  - `acc` is not cleared.
- **Async reset mid-block:** discards everything and returns all state to reset values.
- **Arithmetic:** rounding, special values and zero handling are whatever the adder produces. This block never inspects or alters `i_add_result`.

## Timing
- **Reset values:**
  - `state`=`ACC`, `acc`=0, `cnt`=0.
  - `o_out_valid`=0, `o_out_data`=0, `o_count`=0.
  - `o_add_a`=`o_add_b`=0, `o_add_op`=0.
  - `o_in_ready`=1 once `i_rst_n` is high.
- **Without the macro:**
  - `o_add_a`=acc, `o_add_b`=`i_in_data`, `o_add_op`=`i_in_sub`, all combinational.
  - Throughput is one operand per cycle.
  - `o_out_valid` rises the cycle after the `LEN`th handshake.
- `o_count` equals `cnt` and is registered.
- `o_out_data` equals `acc` and is registered.

## Configuration
- **Macro `FPACC_OPREG_EN`:**
  - **Defined:** adder operands are registered to cut the input-to-adder path.
    - A non-first handshake latches `o_add_a`/`o_add_b`/`o_add_op` and moves to `EXEC`.
    - In `EXEC`, `o_in_ready`=0 and `acc <= i_add_result`. The FSM then goes to `ACC`, or to `HOLD` if this was the `LEN`th operand.
    - Throughput is one operand per 2 cycles; `o_out_valid` rises 2 cycles after the last handshake.
    - First operands still bypass in 1 cycle.
    - `i_clear` in `EXEC` abandons the operation.
  - **Undefined:** there is no `EXEC` state and operands are combinational as described under Timing.

## Test plan
- **Add block:** `LEN`=4; stream 3F800000, 40000000, 3F000000, 3F000000, all add, valid every cycle. Required: `o_out_data`=40800000 (4.0), `o_out_valid` high the cycle after the 4th handshake (2 cycles with the macro).
- **Subtract on first operand:** first operand 40000000 with sub=1, then 3F800000 add, `LEN`=2. Required: `acc` after the first operand = C0000000; result = BF800000 (−1.0).
- **Output backpressure:** `i_out_ready` held 0 for 5 cycles in `HOLD`. Required: `o_out_data` stable, `o_in_ready`=0 throughout, no handshake; the next block starts with `cnt`=0.
- **Clear mid-block:** `i_clear` asserted with `i_in_valid`=1 after 2 operands. Required: that operand is not accepted, `o_count`=0, and the next block sum excludes the earlier operands.
- **Async reset:** `i_rst_n` dropped mid-cycle in `HOLD`. Required: `o_out_valid`=0 immediately and all outputs at reset values.
- **`LEN`=1:** input 40400000 with sub=1. Required: output C0400000; the adder result is ignored.
